// File: rtl/exhaustive_adder_checker.sv
// Sweeps every {a,b} vector through an external adder, samples its sum after a
// programmable settle time and accumulates error statistics against a + b.
module exhaustive_adder_checker #(
    parameter int OP_W          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [OP_W:0]       dut_po,
    output logic [2*OP_W-1:0]   pi,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2*OP_W:0]     err_count,
    output logic [OP_W+1:0]     max_abs_err,
    output logic [3*OP_W+1:0]   sum_abs_err,
    output logic [2*OP_W-1:0]   first_fail_vec
);

    localparam int VEC_W   = 2 * OP_W;
    localparam int ERR_W   = 2 * OP_W + 1;
    localparam int DIFF_W  = OP_W + 2;
    localparam int SUM_W   = 3 * OP_W + 2;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VEC_W-1:0]     pi_d;
    logic                 busy_d, done_d, pass_d;
    logic [ERR_W-1:0]     err_d;
    logic [DIFF_W-1:0]    max_d;
    logic [SUM_W-1:0]     sum_d;
    logic [VEC_W-1:0]     ffv_d;

    logic [OP_W-1:0]      a_p0, b_p0;
    logic [OP_W:0]        golden_p0;
    logic [DIFF_W-1:0]    diff_p0;

    // Exact |po - golden| evaluated one bit wider than either operand, so the
    // signed difference can never wrap.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [OP_W:0] po,
                                                   input logic [OP_W:0] gold);
        logic signed [DIFF_W-1:0] d;
        d = $signed({1'b0, po}) - $signed({1'b0, gold});
        abs_diff = (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
    endfunction

    // Stage p0: golden sum and error magnitude for the vector on pi
    assign a_p0      = pi[VEC_W-1:OP_W];
    assign b_p0      = pi[OP_W-1:0];
    assign golden_p0 = {1'b0, a_p0} + {1'b0, b_p0};
    assign diff_p0   = abs_diff(dut_po, golden_p0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pi_d    = pi;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        max_d   = max_abs_err;
        sum_d   = sum_abs_err;
        ffv_d   = first_fail_vec;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                    pi_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    max_d   = '0;
                    sum_d   = '0;
                    ffv_d   = '0;
                end
            end
            SETTLE: begin
                // abort also beats the final sample, leaving done low
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (diff_p0 != '0) begin
                        err_d = err_count + ERR_W'(1);
                        sum_d = sum_abs_err + SUM_W'(diff_p0);
                        if (diff_p0 > max_abs_err) begin
                            max_d = diff_p0;
                        end
                        if (err_count == '0) begin
                            ffv_d = pi;
                        end
                    end
                    if (pi == '1) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        pi_d  = pi + VEC_W'(1);
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Stage p1: registered sweep state and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            pi             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            max_abs_err    <= '0;
            sum_abs_err    <= '0;
            first_fail_vec <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pi             <= pi_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_d;
            max_abs_err    <= max_d;
            sum_abs_err    <= sum_d;
            first_fail_vec <= ffv_d;
        end
    end

endmodule

// File: doc/exhaustive_adder_checker.md
Name: exhaustive_adder_checker

Overview:
- Sequential stimulus and response stage that wraps a combinational approximate adder under check.
- Drives every input vector `{a,b}` onto the adder's `pi` bus and samples the adder's `po` after a programmable settle time.
- Compares each sample against the exact sum and accumulates error statistics: error count, maximum absolute error, sum of absolute errors, and first failing vector.
- Replaces the print-and-diff flow with an on-chip, single-run verdict for each adder netlist.

Parameters:
- OP_W, 2, operand width; `pi` is 2*OP_W bits and `po` is OP_W+1 bits.
- SETTLE_CYCLES, 1, clock cycles each vector is held before `po` is sampled (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that starts a sweep.
- abort  in  1  stops a running sweep.
- dut_po  in  OP_W+1  adder output under check.
- pi  out  2*OP_W  adder input vector; `pi[2*OP_W-1:OP_W]` = a, `pi[OP_W-1:0]` = b.
- busy  out  1  high while a sweep runs.
- done  out  1  high after a completed sweep; held until the next start or reset.
- pass  out  1  valid with `done`; 1 when `err_count` = 0.
- err_count  out  2*OP_W+1  number of mismatching vectors.
- max_abs_err  out  OP_W+2  largest |po − (a+b)|.
- sum_abs_err  out  3*OP_W+2  sum of |po − (a+b)| over all vectors.
- first_fail_vec  out  2*OP_W  first mismatching `pi` value; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 (`pi`=0, busy=0, done=0, pass=0, all statistics 0).
- States: IDLE, SETTLE, DONE.
- IDLE or DONE, start=1 at an edge:
  - `pi`<=0, all statistics cleared, done<=0, pass<=0, busy<=1.
  - Settle counter loaded with SETTLE_CYCLES−1; go to SETTLE.
- SETTLE, counter ≠ 0: decrement, hold `pi`.
- SETTLE, counter = 0 (the sample edge):
  - golden = a + b, unsigned, OP_W+1 bits.
  - diff = |dut_po − golden|, computed at OP_W+2 bits with no wrap.
  - If diff ≠ 0:
    - err_count += 1;
    - sum_abs_err += diff;
    - max_abs_err <= max(max_abs_err, diff);
    - first_fail_vec <= `pi` only if err_count was 0 before this edge.
  - If `pi` is all-ones (last vector): busy<=0, done<=1, pass <= (updated err_count = 0), go to DONE; `pi` holds its last value.
  - Otherwise: `pi` <= `pi`+1, reload the counter, stay in SETTLE.
- Vector order is natural binary 0 … 2^(2*OP_W)−1.
- Each vector occupies SETTLE_CYCLES clocks. `done` rises SETTLE_CYCLES·2^(2*OP_W) edges after the start edge (16 with defaults).
- start while busy: ignored.
- abort while busy: go to IDLE at that edge; busy<=0, done stays 0; statistics and `pi` frozen.
- abort and last-sample on the same edge: abort wins, done stays 0.
- abort in IDLE or DONE: no effect.
- start and abort on the same edge in IDLE/DONE: start wins.
- Reset mid-sweep: immediate return to reset values; no partial statistics are retained.
- Statistic widths are sized so no counter can overflow for any OP_W.
- X on `dut_po` at a sample edge is not filtered; verification must never drive X.

Test Plan:
- Exact adder model (`dut_po` = a+b), defaults, start pulse:
  - busy for 16 cycles, then done=1, pass=1;
  - err_count=0, max=0, sum=0, first_fail_vec=0.
- Stuck-at-zero model (`dut_po`=0):
  - err_count=15, max_abs_err=6, sum_abs_err=48;
  - first_fail_vec=4'b0001, pass=0.
- Carry-dropped model (`po[2]` forced 0):
  - err_count=6, max_abs_err=4, sum_abs_err=24;
  - first_fail_vec=4'b0111, pass=0.
- SETTLE_CYCLES=3 with a model that applies `pi` with 2-cycle latency:
  - pass=1;
  - done rises 48 edges after start;
  - `pi` changes only every 3rd edge.
- Start re-pulsed at cycle 5 mid-sweep: ignored, done at the same edge as with no re-pulse. Then start again in DONE with the stuck-at model: statistics cleared and recomputed, results as in the stuck-at scenario.
- abort at cycle 7: busy=0, done=0, statistics frozen. Separately, rst_n low mid-sweep asynchronously: all outputs 0 before the next edge.
